// File: rtl/mc_if.sv
// Control/status bundle between the multicycle MIPS controller and its datapath.
// The controller uses the master modport; the datapath side uses slave.
interface mc_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcen;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;
    logic       illegal_instr;
    logic       mem_timeout;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, iord, memwrite, irwrite, pcen, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, state, illegal_instr, mem_timeout
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, iord, memwrite, irwrite, pcen, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, state, illegal_instr, mem_timeout
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM with memory wait-state handshake, watchdog and illegal-op report.
// Optional macro MC_BNE_EN adds bne (op 000101) through the BRANCH state.
module mc_controller #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic resetn,
    mc_if.master bus
);
    localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    state_t        state_r, state_next_s;
    logic [CW-1:0] wait_cnt_r, wait_cnt_next_s;
    logic          in_mem_s, timeout_s;

    function automatic logic funct_legal(input logic [5:0] f);
        return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
               (f == 6'b100101) || (f == 6'b101010);
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // State and watchdog registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= S_IDLE;
            wait_cnt_r <= '0;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_cnt_next_s;
        end
    end

    // Watchdog: counting only while stalled, so every exit from a memory state leaves it at zero
    always_comb begin
        in_mem_s  = (state_r == S_FETCH) || (state_r == S_MEMRD) || (state_r == S_MEMWR);
        timeout_s = in_mem_s && !bus.mem_ready && (wait_cnt_r == WAIT_LIM);
        if (in_mem_s && !bus.mem_ready && !timeout_s) begin
            wait_cnt_next_s = wait_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_next_s = '0;
        end
    end

    // Next-state and Moore outputs; irwrite/pcen gated by mem_ready/zero
    always_comb begin
        state_next_s      = S_IDLE;
        bus.mem_req       = 1'b0;
        bus.iord          = 1'b0;
        bus.memwrite      = 1'b0;
        bus.irwrite       = 1'b0;
        bus.pcen          = 1'b0;
        bus.regdst        = 1'b0;
        bus.memtoreg      = 1'b0;
        bus.regwrite      = 1'b0;
        bus.alusrca       = 1'b0;
        bus.alusrcb       = 2'b00;
        bus.pcsrc         = 2'b00;
        bus.alucontrol    = 3'b000;
        bus.illegal_instr = 1'b0;
        bus.mem_timeout   = timeout_s;
        bus.state         = state_r;
        case (state_r)
            S_IDLE: state_next_s = S_FETCH;
            S_FETCH: begin
                bus.mem_req    = 1'b1;
                bus.alusrcb    = 2'b01;
                bus.alucontrol = 3'b010;
                bus.irwrite    = bus.mem_ready;
                bus.pcen       = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_next_s = S_DECODE;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                bus.alusrcb    = 2'b11;
                bus.alucontrol = 3'b010;
                case (bus.op)
                    OP_LW, OP_SW: state_next_s = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct_legal(bus.funct)) begin
                            state_next_s = S_EXEC;
                        end else begin
                            state_next_s      = S_FETCH;
                            bus.illegal_instr = 1'b1;
                        end
                    end
                    OP_BEQ:  state_next_s = S_BRANCH;
`ifdef MC_BNE_EN
                    OP_BNE:  state_next_s = S_BRANCH;
`endif
                    OP_ADDI: state_next_s = S_ADDIEX;
                    OP_J:    state_next_s = S_JUMP;
                    default: begin
                        state_next_s      = S_FETCH;
                        bus.illegal_instr = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.alusrca    = 1'b1;
                bus.alusrcb    = 2'b10;
                bus.alucontrol = 3'b010;
                if (bus.op == OP_LW) begin
                    state_next_s = S_MEMRD;
                end else if (bus.op == OP_SW) begin
                    state_next_s = S_MEMWR;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_MEMRD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
                if (bus.mem_ready) begin
                    state_next_s = S_MEMWB;
                end else if (timeout_s) begin
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_MEMRD;
                end
            end
            S_MEMWB: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = 1'b1;
                state_next_s = S_FETCH;
            end
            S_MEMWR: begin
                bus.mem_req  = 1'b1;
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
                if (bus.mem_ready || timeout_s) begin
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_MEMWR;
                end
            end
            S_EXEC: begin
                bus.alusrca    = 1'b1;
                bus.alucontrol = funct_alu(bus.funct);
                state_next_s   = S_ALUWB;
            end
            S_ALUWB: begin
                bus.regwrite = 1'b1;
                bus.regdst   = 1'b1;
                state_next_s = S_FETCH;
            end
            S_BRANCH: begin
                bus.alusrca    = 1'b1;
                bus.alucontrol = 3'b110;
                bus.pcsrc      = 2'b01;
`ifdef MC_BNE_EN
                if (bus.op == OP_BNE) begin
                    bus.pcen = ~bus.zero;
                end else begin
                    bus.pcen = bus.zero;
                end
`else
                bus.pcen = bus.zero;
`endif
                state_next_s = S_FETCH;
            end
            S_ADDIEX: begin
                bus.alusrca    = 1'b1;
                bus.alusrcb    = 2'b10;
                bus.alucontrol = 3'b010;
                state_next_s   = S_ADDIWB;
            end
            S_ADDIWB: begin
                bus.regwrite = 1'b1;
                state_next_s = S_FETCH;
            end
            S_JUMP: begin
                bus.pcsrc    = 2'b10;
                bus.pcen     = 1'b1;
                state_next_s = S_FETCH;
            end
            default: begin
                // unused codes: park in IDLE with everything quiet
                bus.mem_timeout = 1'b0;
                state_next_s    = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: stimulus queues per-cycle expected outputs, a monitor compares.
module tb_mc_controller;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mc_if bus_if();

    mc_controller #(.WAIT_MAX(15)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if)
    );

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, JMP = 6'b000010;

    typedef struct {
        logic [21:0] v;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [21:0] act;
    int          checks = 0;
    int          failures = 0;

    // Expected outputs: st=state, rdy=mem_ready (FETCH gating), pc=expected BRANCH pcen
    function automatic logic [21:0] ev(input logic [3:0] st, input logic rdy, input logic pc,
                                       input logic [2:0] alu, input logic ill, input logic to);
        logic mr, io, mw, ir, pe, rd, mt, rw, sa;
        logic [1:0] sbv, ps;
        logic [2:0] ac;
        {mr, io, mw, ir, pe, rd, mt, rw, sa} = 9'b0;
        sbv = 2'b00; ps = 2'b00; ac = 3'b000;
        case (st)
            4'd1:  begin mr = 1'b1; sbv = 2'b01; ac = 3'b010; ir = rdy; pe = rdy; end
            4'd2:  begin sbv = 2'b11; ac = 3'b010; end
            4'd3:  begin sa = 1'b1; sbv = 2'b10; ac = 3'b010; end
            4'd4:  begin mr = 1'b1; io = 1'b1; end
            4'd5:  begin rw = 1'b1; mt = 1'b1; end
            4'd6:  begin mr = 1'b1; io = 1'b1; mw = 1'b1; end
            4'd7:  begin sa = 1'b1; ac = alu; end
            4'd8:  begin rw = 1'b1; rd = 1'b1; end
            4'd9:  begin sa = 1'b1; ac = 3'b110; ps = 2'b01; pe = pc; end
            4'd10: begin sa = 1'b1; sbv = 2'b10; ac = 3'b010; end
            4'd11: begin rw = 1'b1; end
            4'd12: begin ps = 2'b10; pe = 1'b1; end
            default: ;
        endcase
        return {mr, io, mw, ir, pe, rd, mt, rw, sa, sbv, ps, ac, st, ill, to};
    endfunction

    task automatic cyc(input string nm, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic r, input logic [21:0] e);
        bus_if.op = o; bus_if.funct = f; bus_if.zero = z; bus_if.mem_ready = r;
        sb.push_back('{v: e, name: nm});
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            act = {bus_if.mem_req, bus_if.iord, bus_if.memwrite, bus_if.irwrite, bus_if.pcen,
                   bus_if.regdst, bus_if.memtoreg, bus_if.regwrite, bus_if.alusrca,
                   bus_if.alusrcb, bus_if.pcsrc, bus_if.alucontrol, bus_if.state,
                   bus_if.illegal_instr, bus_if.mem_timeout};
            checks++;
            if (act !== mon_e.v) begin
                failures++;
                $display("FAIL %s: got %b expected %b", mon_e.name, act, mon_e.v);
            end
        end
    end

    logic [5:0] fn[5];
    logic [2:0] fa[5];

    initial begin
        fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        fa = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        resetn = 1'b0;
        bus_if.op = 6'd0; bus_if.funct = 6'd0; bus_if.zero = 1'b0; bus_if.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset0", RT, 6'd0, 1'b0, 1'b1, ev(4'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("reset1", RT, 6'd0, 1'b0, 1'b1, ev(4'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
        resetn = 1'b1;
        cyc("idle", RT, 6'd0, 1'b0, 1'b1, ev(4'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));

        for (int i = 0; i < 5; i++) begin
            cyc("r_fetch", RT, fn[i], 1'b0, 1'b1, ev(4'd1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
            cyc("r_decode", RT, fn[i], 1'b0, 1'b1, ev(4'd2, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
            cyc("r_exec", RT, fn[i], 1'b0, 1'b1, ev(4'd7, 1'b1, 1'b0, fa[i], 1'b0, 1'b0));
            cyc("r_aluwb", RT, fn[i], 1'b0, 1'b1, ev(4'd8, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
        end

        cyc("lw_fetch", LW, 6'd0, 1'b0, 1'b1, ev(4'd1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("lw_decode", LW, 6'd0, 1'b0, 1'b0, ev(4'd2, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("lw_memadr", LW, 6'd0, 1'b0, 1'b0, ev(4'd3, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++)
            cyc("lw_memrd_wait", LW, 6'd0, 1'b0, 1'b0, ev(4'd4, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("lw_memrd_done", LW, 6'd0, 1'b0, 1'b1, ev(4'd4, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("lw_memwb", LW, 6'd0, 1'b0, 1'b0, ev(4'd5, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));

        cyc("sw_fetch", SW, 6'd0, 1'b0, 1'b1, ev(4'd1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("sw_decode", SW, 6'd0, 1'b0, 1'b1, ev(4'd2, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("sw_memadr", SW, 6'd0, 1'b0, 1'b1, ev(4'd3, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("sw_memwr", SW, 6'd0, 1'b0, 1'b1, ev(4'd6, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));

        for (int z = 1; z >= 0; z--) begin
            cyc("beq_fetch", BEQ, 6'd0, 1'(z), 1'b1, ev(4'd1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
            cyc("beq_decode", BEQ, 6'd0, 1'(z), 1'b1, ev(4'd2, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
            cyc("beq_branch", BEQ, 6'd0, 1'(z), 1'b1, ev(4'd9, 1'b1, 1'(z), 3'b000, 1'b0, 1'b0));
        end

        cyc("addi_fetch", ADDI, 6'd0, 1'b0, 1'b1, ev(4'd1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("addi_decode", ADDI, 6'd0, 1'b0, 1'b1, ev(4'd2, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("addi_ex", ADDI, 6'd0, 1'b0, 1'b1, ev(4'd10, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("addi_wb", ADDI, 6'd0, 1'b0, 1'b1, ev(4'd11, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("j_fetch", JMP, 6'd0, 1'b0, 1'b1, ev(4'd1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("j_decode", JMP, 6'd0, 1'b0, 1'b1, ev(4'd2, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("j_jump", JMP, 6'd0, 1'b0, 1'b1, ev(4'd12, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));

        // FETCH watchdog: pulse on the 16th stalled cycle, then a fresh 15-cycle window
        for (int i = 0; i < 16; i++)
            cyc("fetch_timeout", JMP, 6'd0, 1'b0, 1'b0,
                ev(4'd1, 1'b0, 1'b0, 3'b000, 1'b0, 1'(i == 15)));
        for (int i = 0; i < 15; i++)
            cyc("fetch_rewait", JMP, 6'd0, 1'b0, 1'b0, ev(4'd1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("fetch_after_to", JMP, 6'd0, 1'b0, 1'b1, ev(4'd1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("j2_decode", JMP, 6'd0, 1'b0, 1'b1, ev(4'd2, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("j2_jump", JMP, 6'd0, 1'b0, 1'b1, ev(4'd12, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));

        // mem_ready on the limit cycle completes normally
        cyc("sw2_fetch", SW, 6'd0, 1'b0, 1'b1, ev(4'd1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("sw2_decode", SW, 6'd0, 1'b0, 1'b1, ev(4'd2, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("sw2_memadr", SW, 6'd0, 1'b0, 1'b1, ev(4'd3, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
        for (int i = 0; i < 15; i++)
            cyc("sw2_memwr_wait", SW, 6'd0, 1'b0, 1'b0, ev(4'd6, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("sw2_memwr_limit", SW, 6'd0, 1'b0, 1'b1, ev(4'd6, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));

        // MEMRD watchdog abort returns to FETCH
        cyc("lw2_fetch", LW, 6'd0, 1'b0, 1'b1, ev(4'd1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("lw2_decode", LW, 6'd0, 1'b0, 1'b1, ev(4'd2, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("lw2_memadr", LW, 6'd0, 1'b0, 1'b1, ev(4'd3, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
        for (int i = 0; i < 16; i++)
            cyc("lw2_memrd_to", LW, 6'd0, 1'b0, 1'b0,
                ev(4'd4, 1'b0, 1'b0, 3'b000, 1'b0, 1'(i == 15)));
        cyc("lw2_refetch", LW, 6'd0, 1'b0, 1'b0, ev(4'd1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("lw2_refetch_ok", JMP, 6'd0, 1'b0, 1'b1, ev(4'd1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("j3_decode", JMP, 6'd0, 1'b0, 1'b1, ev(4'd2, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("j3_jump", JMP, 6'd0, 1'b0, 1'b1, ev(4'd12, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));

`ifdef MC_BNE_EN
        for (int z = 0; z < 2; z++) begin
            cyc("bne_fetch", BNE, 6'd0, 1'(z), 1'b1, ev(4'd1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
            cyc("bne_decode", BNE, 6'd0, 1'(z), 1'b1, ev(4'd2, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
            cyc("bne_branch", BNE, 6'd0, 1'(z), 1'b1, ev(4'd9, 1'b1, 1'(z == 0), 3'b000, 1'b0, 1'b0));
        end
`else
        cyc("bne_fetch", BNE, 6'd0, 1'b0, 1'b1, ev(4'd1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("bne_illegal", BNE, 6'd0, 1'b0, 1'b1, ev(4'd2, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0));
`endif
        cyc("badfn_fetch", RT, 6'b000001, 1'b0, 1'b1, ev(4'd1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("badfn_decode", RT, 6'b000001, 1'b0, 1'b1, ev(4'd2, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0));
        cyc("badop_fetch", 6'b111111, 6'd0, 1'b0, 1'b1, ev(4'd1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("badop_decode", 6'b111111, 6'd0, 1'b0, 1'b1, ev(4'd2, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0));

        // asynchronous reset in the middle of a read
        cyc("lw3_fetch", LW, 6'd0, 1'b0, 1'b1, ev(4'd1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("lw3_decode", LW, 6'd0, 1'b0, 1'b0, ev(4'd2, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("lw3_memadr", LW, 6'd0, 1'b0, 1'b0, ev(4'd3, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("lw3_memrd", LW, 6'd0, 1'b0, 1'b0, ev(4'd4, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
        resetn = 1'b0;
        cyc("midrst0", LW, 6'd0, 1'b0, 1'b1, ev(4'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("midrst1", LW, 6'd0, 1'b0, 1'b1, ev(4'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
        resetn = 1'b1;
        cyc("post_rst_idle", LW, 6'd0, 1'b0, 1'b0, ev(4'd0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));
        cyc("post_rst_fetch", LW, 6'd0, 1'b0, 1'b0, ev(4'd1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0));

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle MIPS control unit: sequences the shared-memory, single-ALU multicycle datapath through fetch/decode/execute/memory/writeback states.
- Same instruction subset as the single-cycle decoders: R-type add/sub/and/or/slt, lw, sw, beq, addi, j.
- Adds memory wait-state handshake (mem_req/mem_ready), timeout watchdog and illegal-instruction reporting.
- Drives datapath enables/selects as Moore outputs; pcen and irwrite are additionally gated by mem_ready/zero.

Parameters:
WAIT_MAX, 15, max cycles a memory state waits for mem_ready before abort; counter width clog2(WAIT_MAX+1).

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous, active-low reset
op  in  6  IR[31:26], stable from DECODE to end of instruction
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory access complete this cycle
mem_req  out  1  memory access request
iord  out  1  0 = PC address, 1 = ALUOut address
memwrite  out  1  memory write strobe (with mem_req)
irwrite  out  1  IR load enable
pcen  out  1  PC write enable
regdst  out  1  1 = rd, 0 = rt
memtoreg  out  1  1 = MDR, 0 = ALUOut
regwrite  out  1  register file write enable
alusrca  out  1  0 = PC, 1 = regA
alusrcb  out  2  00 regB, 01 const 4, 10 signimm, 11 signimm<<2
pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
state  out  4  current state encoding (debug)
illegal_instr  out  1  one-cycle pulse, undecodable op/funct
mem_timeout  out  1  one-cycle pulse, watchdog abort

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12. Codes 13-15 -> IDLE next cycle, all outputs 0.
- Reset (resetn=0, any time, including mid-access): state=IDLE, wait counter=0. Every output is 0 in IDLE. IDLE -> FETCH unconditionally on the first clock after release.
- Default for every output not listed for a state: 0.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00.
  - irwrite=pcen=mem_ready.
  - mem_ready=1 -> DECODE; otherwise stay.
- DECODE: alusrca=0, alusrcb=11, alucontrol=010 (branch target into ALUOut). Next state:
  - lw (100011) / sw (101011) -> MEMADR
  - R-type (000000) with legal funct (100000, 100010, 100100, 100101, 101010) -> EXEC
  - beq (000100) -> BRANCH
  - addi (001000) -> ADDIEX
  - j (000010) -> JUMP
  - any other op or funct -> FETCH, with illegal_instr=1 for that cycle
- MEMADR: alusrca=1, alusrcb=10, alucontrol=010. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_req=1, iord=1. mem_ready -> MEMWB; else stay.
- MEMWB: regwrite=1, regdst=0, memtoreg=1 -> FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1. mem_ready -> FETCH; else stay.
- EXEC: alusrca=1, alusrcb=00, alucontrol from funct: add 010, sub 110, and 000, or 001, slt 111 -> ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0 -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, pcen=zero -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, alucontrol=010 -> ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0 -> FETCH.
- JUMP: pcsrc=10, pcen=1 -> FETCH.
- Cycle counts at zero wait: R/addi/sw 4, lw 5, beq/j 3. Each wait cycle adds 1.
- Watchdog: counter clears on entry to each memory state (FETCH, MEMRD, MEMWR) and increments each cycle in it with mem_ready=0.
  - On the cycle counter==WAIT_MAX with mem_ready=0: mem_timeout=1, next=FETCH (refetch same PC; no PC/IR/register update).
  - A FETCH timeout re-enters FETCH with counter cleared.
  - mem_ready on that same cycle wins: normal completion, no timeout.

Optional Feature:
MC_BNE_EN:
- Defined: op 000101 (bne) decodes to BRANCH. In BRANCH, pcen=~zero for bne and pcen=zero for beq.
  - op is held in IR, so no extra state is needed.
- Undefined: 000101 is illegal (illegal_instr pulse, DECODE -> FETCH).

Test Plan:
- Reset: resetn=0 mid-MEMRD -> state=0, all outputs 0. After release: IDLE, then FETCH with mem_req=1.
- R-type add (op=0, funct=100000), mem_ready always 1 -> states 1,2,7,8; alucontrol=010 in EXEC; regwrite=1, regdst=1 in ALUWB; 4 cycles.
- lw with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with regwrite=1, memtoreg=1; total 8 cycles.
- beq, zero=1 then zero=0 -> pcen=1 with pcsrc=01, then pcen=0; 3 cycles each.
- FETCH with mem_ready stuck 0, WAIT_MAX=15 -> mem_timeout pulse on 16th FETCH cycle, irwrite/pcen never 1, FETCH restarts.
- op=000101 -> illegal_instr pulse in DECODE, then FETCH. With MC_BNE_EN and zero=0 -> BRANCH with pcen=1.
